// File: rtl/bus_monitor_master_if.sv
// Bus monitor interface: host byte stream (command in, reply out) plus the
// memory-bus initiator signals and the ownership/busy status lines.
interface bus_monitor_master_if #(
   parameter int WIDTH = 32
);
   logic [7:0]       in_byte;
   logic             in_valid;
   logic [7:0]       out_byte;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] mbus_aout;
   logic [WIDTH-1:0] mbus_dout;
   logic [WIDTH-1:0] mbus_din;
   logic             mbus_wen;
   logic             bus_own;
   logic             busy;

   // The bus monitor itself drives the reply stream and the memory bus.
   modport master (
      input  in_byte, in_valid, out_ready, mbus_din,
      output out_byte, out_valid, mbus_aout, mbus_dout, mbus_wen, bus_own, busy
   );

   // Host/receiver plus memory side.
   modport slave (
      output in_byte, in_valid, out_ready, mbus_din,
      input  out_byte, out_valid, mbus_aout, mbus_dout, mbus_wen, bus_own, busy
   );
endinterface

// File: rtl/bus_monitor_master.sv
// Byte-stream command parser that acts as a memory-bus initiator.
// Frames: 'H' take bus, 'G' release bus, 'W' A3..A0 D3..D0 write,
// 'R' A3..A0 read (4-byte reply, MSB first). Frames carry exactly four
// bytes per field, so WIDTH must be 32.
module bus_monitor_master #(
   parameter int WIDTH   = 32,
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 100000
) (
   input  logic                 clk,
   input  logic                 reset,
   bus_monitor_master_if.master bus
);

   localparam logic [7:0] CH_H    = 8'h48;
   localparam logic [7:0] CH_G    = 8'h47;
   localparam logic [7:0] CH_W    = 8'h57;
   localparam logic [7:0] CH_R    = 8'h52;
   localparam logic [7:0] CH_DOT  = 8'h2E;
   localparam logic [7:0] CH_QST  = 8'h3F;
   localparam logic [7:0] CH_BANG = 8'h21;

   localparam int TW = $clog2(TIMEOUT);
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      WRITE,
      RWAIT,
      RSAMP,
      SEND
   } state_t;

   state_t           state_q;
   logic             is_wr_q;    // current frame is 'W' (else 'R')
   logic [1:0]       bcnt_q;     // byte index within a 4-byte field
   logic [TW-1:0]    tcnt_q;     // idle cycles since last frame byte
   logic [LW-1:0]    lat_q;      // read-latency wait counter
   logic [WIDTH-1:0] addr_q;     // address shift register
   logic [WIDTH-1:0] data_q;     // write-data shift register
   logic [WIDTH-1:0] rsh_q;      // pending reply bytes, next one in MSBs
   logic [1:0]       rem_q;      // reply bytes still to send after out_byte
   logic [WIDTH-1:0] aout_q;
   logic [WIDTH-1:0] dout_q;
   logic             wen_q;
   logic             own_q;
   logic [7:0]       out_byte_q;
   logic             out_valid_q;

   assign bus.mbus_aout = aout_q;
   assign bus.mbus_dout = dout_q;
   assign bus.mbus_wen  = wen_q;
   assign bus.bus_own   = own_q;
   assign bus.out_byte  = out_byte_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q != IDLE);

   // Frame parser, bus sequencer and reply shifter in one registered FSM.
   always_ff @(posedge clk) begin
      // NOTE: every register here, including the shift registers, is reset so a
      // reset mid-frame leaves no stale address/data that a later frame could leak.
      if (reset) begin
         state_q     <= IDLE;
         is_wr_q     <= 1'b0;
         bcnt_q      <= '0;
         tcnt_q      <= '0;
         lat_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         rsh_q       <= '0;
         rem_q       <= '0;
         aout_q      <= '0;
         dout_q      <= '0;
         wen_q       <= 1'b0;
         own_q       <= 1'b0;
         out_byte_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below reads
         // the pre-edge value of each register regardless of statement order.
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  case (bus.in_byte)
                     CH_H, CH_G: begin
                        own_q       <= (bus.in_byte == CH_H);
                        out_byte_q  <= CH_DOT;
                        out_valid_q <= 1'b1;
                        rem_q       <= '0;
                        state_q     <= SEND;
                     end
                     CH_W, CH_R: begin
                        is_wr_q <= (bus.in_byte == CH_W);
                        bcnt_q  <= '0;
                        tcnt_q  <= '0;
                        state_q <= ADDR;
                     end
                     default: begin
                        out_byte_q  <= CH_QST;
                        out_valid_q <= 1'b1;
                        rem_q       <= '0;
                        state_q     <= SEND;
                     end
                  endcase
               end
            end

            ADDR, DATA: begin
               if (bus.in_valid) begin
                  tcnt_q <= '0;
                  bcnt_q <= bcnt_q + 2'd1;
                  if (state_q == ADDR) begin
                     addr_q <= {addr_q[WIDTH-9:0], bus.in_byte};
                  end else begin
                     data_q <= {data_q[WIDTH-9:0], bus.in_byte};
                  end
                  if (bcnt_q == 2'd3) begin
                     if (state_q == ADDR && is_wr_q) begin
                        state_q <= DATA;
                     end else if (!own_q) begin
                        // Frame consumed but the CPU owns the bus: refuse.
                        out_byte_q  <= CH_BANG;
                        out_valid_q <= 1'b1;
                        rem_q       <= '0;
                        state_q     <= SEND;
                     end else if (state_q == ADDR) begin
                        aout_q  <= {addr_q[WIDTH-9:0], bus.in_byte};
                        lat_q   <= '0;
                        state_q <= RWAIT;
                     end else begin
                        aout_q  <= addr_q;
                        dout_q  <= {data_q[WIDTH-9:0], bus.in_byte};
                        wen_q   <= 1'b1;
                        state_q <= WRITE;
                     end
                  end
               end else if (tcnt_q == TO_LAST) begin
                  // Host went quiet mid-frame: drop it silently.
                  tcnt_q  <= '0;
                  bcnt_q  <= '0;
                  state_q <= IDLE;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end

            WRITE: begin
               wen_q       <= 1'b0;
               out_byte_q  <= CH_DOT;
               out_valid_q <= 1'b1;
               rem_q       <= '0;
               state_q     <= SEND;
            end

            RWAIT: begin
               if (lat_q == LAT_LAST) begin
                  state_q <= RSAMP;
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end

            RSAMP: begin
               out_byte_q  <= bus.mbus_din[WIDTH-1 -: 8];
               rsh_q       <= {bus.mbus_din[WIDTH-9:0], 8'h00};
               out_valid_q <= 1'b1;
               rem_q       <= 2'd3;
               state_q     <= SEND;
            end

            SEND: begin
               if (bus.out_ready) begin
                  if (rem_q == 2'd0) begin
                     out_valid_q <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     out_byte_q <= rsh_q[WIDTH-1 -: 8];
                     rsh_q      <= {rsh_q[WIDTH-9:0], 8'h00};
                     rem_q      <= rem_q - 2'd1;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
